// File: rtl/stream_arb.sv
// stream_arb: N-way round-robin stream arbiter with packet lock.
// Ports: clk, rst_n (async low), clk_en; in_vld/in_rdy/in_dat/in_last
//   per requester (packed, requester i at bits [i*DW +: DW]);
//   out_vld/out_rdy/out_dat/out_last/out_idx registered output stage.
module stream_arb #(
   parameter int DW = 32,
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  logic [N-1:0]    in_vld,
   output logic [N-1:0]    in_rdy,
   input  logic [N*DW-1:0] in_dat,
   input  logic [N-1:0]    in_last,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [DW-1:0]   out_dat,
   output logic            out_last,
   output logic [IW-1:0]   out_idx
);

   logic          full_q, full_d;
   logic          lock_q, lock_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          last_q, last_d;
   logic [IW-1:0] idx_q, idx_d;

   logic          load;
   logic          rr_hit;
   logic [IW-1:0] rr_sel;
   logic [IW-1:0] sel;
   logic          grant_ok;
   logic          take;
   logic          give;
   logic [DW-1:0] sel_dat;
   logic          sel_last;
   logic [IW-1:0] sel_nxt;

   assign out_vld = full_q && clk_en;
   assign load    = clk_en && (!full_q || out_rdy);
   assign give    = out_vld && out_rdy;

   // Round-robin search starting at ptr, wrapping at N.
   always_comb begin
      int j;
      j      = 0;
      rr_hit = 1'b0;
      rr_sel = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!rr_hit && in_vld[j[IW-1:0]]) begin
            rr_hit = 1'b1;
            rr_sel = j[IW-1:0];
         end
      end
   end

   // A held lock owns the grant even while its requester is idle.
   assign sel      = lock_q ? lock_idx_q : rr_sel;
   assign grant_ok = lock_q || rr_hit;

   // rst_n gating keeps in_rdy low for the whole reset interval.
   always_comb begin
      in_rdy = '0;
      if (rst_n && load && grant_ok) begin
         in_rdy[sel] = 1'b1;
      end
   end

   assign take     = |(in_vld & in_rdy);
   assign sel_dat  = in_dat[int'(sel)*DW +: DW];
   assign sel_last = in_last[sel];
   assign sel_nxt  = (sel == IW'(N-1)) ? '0 : sel + IW'(1);

   always_comb begin
      full_d     = full_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      dat_d      = dat_q;
      last_d     = last_q;
      idx_d      = idx_q;
      if (take) begin
         full_d = 1'b1;
         dat_d  = sel_dat;
         last_d = sel_last;
         idx_d  = sel;
         if (sel_last) begin
            lock_d = 1'b0;
            ptr_d  = sel_nxt;
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
         end
      end else if (give) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= 1'b0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         ptr_q      <= '0;
         dat_q      <= '0;
         last_q     <= 1'b0;
         idx_q      <= '0;
      end else begin
         full_q     <= full_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
         dat_q      <= dat_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
      end
   end

   assign out_dat  = dat_q;
   assign out_last = last_q;
   assign out_idx  = idx_q;

endmodule
